// File: rtl/program_counter.sv
// program_counter: 16-bit program counter (PCL/PCH) with bus loads and one-cycle carry increment
//   Parameter RESET_PC : value forced into {PCH,PCL} while i_reset is high
//   i_clk              : clock, all updates on rising edge
//   i_reset            : asynchronous active-high reset
//   i_bus_adl/_adh     : address bus values for loading PCL/PCH
//   i_adl_pcl/_adh_pch : select bus value instead of current half
//   i_i_pc             : increment request, carry ripples into PCH in the same cycle
//   i_hold             : stall, freezes all state
//   o_pcl/o_pch/o_pc   : registered program counter
//   o_pclc             : registered carry out of PCL from the last update
module program_counter #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_bus_adl,
    input  logic [7:0]  i_bus_adh,
    input  logic        i_adl_pcl,
    input  logic        i_adh_pch,
    input  logic        i_i_pc,
    input  logic        i_hold,
    output logic [7:0]  o_pcl,
    output logic [7:0]  o_pch,
    output logic        o_pclc,
    output logic [15:0] o_pc
);
    logic [7:0] pcls;
    logic [7:0] pchs;
    logic       carry;
    assign pcls  = i_adl_pcl ? i_bus_adl : o_pcl;
    assign pchs  = i_adh_pch ? i_bus_adh : o_pch;
    assign carry = i_i_pc & (pcls == 8'hFF);
    assign o_pc  = {o_pch, o_pcl};
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pcl  <= RESET_PC[7:0];
            o_pch  <= RESET_PC[15:8];
            o_pclc <= 1'b0;
        end else if (!i_hold) begin
            o_pcl  <= pcls + {7'b0, i_i_pc};
            o_pch  <= pchs + {7'b0, carry};
            o_pclc <= carry;
        end
    end
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed and random checks of program_counter against a 16-bit arithmetic model
module tb_program_counter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  adl = '0;
    logic [7:0]  adh = '0;
    logic        lp = 1'b0;
    logic        hp = 1'b0;
    logic        inc = 1'b0;
    logic        hold = 1'b0;
    logic [7:0]  pcl;
    logic [7:0]  pch;
    logic        pclc;
    logic [15:0] pc;
    logic [15:0] m_pc = 16'h0000;
    logic        m_c = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    program_counter dut (
        .i_clk(clk), .i_reset(rst), .i_bus_adl(adl), .i_bus_adh(adh),
        .i_adl_pcl(lp), .i_adh_pch(hp), .i_i_pc(inc), .i_hold(hold),
        .o_pcl(pcl), .o_pch(pch), .o_pclc(pclc), .o_pc(pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] epc, input logic ec);
        n_cmp++;
        assert ({pclc, pc, pch, pcl} === {ec, epc, epc}) else begin
            n_err++;
            $error("FAIL %s: got pc=%h pch=%h pcl=%h pclc=%b, want pc=%h pclc=%b",
                   tag, pc, pch, pcl, pclc, epc, ec);
        end
    endtask

    task automatic model_edge();
        logic [7:0] lo;
        logic [7:0] hi;
        if (!hold) begin
            lo   = lp ? adl : m_pc[7:0];
            hi   = hp ? adh : m_pc[15:8];
            m_c  = inc && (lo == 8'hFF);
            m_pc = {hi, lo} + {15'b0, inc};
        end
    endtask

    task automatic apply(input string tag, input logic [7:0] a_l, input logic [7:0] a_h,
                         input logic l, input logic h, input logic i, input logic hd);
        adl = a_l; adh = a_h; lp = l; hp = h; inc = i; hold = hd;
        @(posedge clk);
        model_edge();
        #1;
        check(tag, m_pc, m_c);
    endtask

    initial begin
        #12;
        check("reset_init", 16'h0000, 1'b0);
        rst = 1'b0;
        #1;
        apply("load_1234", 8'h34, 8'h12, 1, 1, 0, 0);
        check("load_1234_const", 16'h1234, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        m_pc = 16'h0000; m_c = 1'b0;
        check("async_reset", 16'h0000, 1'b0);
        rst = 1'b0;
        apply("load_12fe", 8'hFE, 8'h12, 1, 1, 0, 0);
        apply("inc_12ff", 8'h00, 8'h00, 0, 0, 1, 0);
        check("inc_12ff_const", 16'h12FF, 1'b0);
        apply("inc_1300", 8'h00, 8'h00, 0, 0, 1, 0);
        check("inc_1300_const", 16'h1300, 1'b1);
        apply("inc_1301", 8'h00, 8'h00, 0, 0, 1, 0);
        check("inc_1301_const", 16'h1301, 1'b0);
        apply("load_ffff", 8'hFF, 8'hFF, 1, 1, 0, 0);
        apply("wrap", 8'h00, 8'h00, 0, 0, 1, 0);
        check("wrap_const", 16'h0000, 1'b1);
        apply("load_inc", 8'hFF, 8'h20, 1, 1, 1, 0);
        check("load_inc_const", 16'h2100, 1'b1);
        apply("adl_only_inc", 8'h7F, 8'h55, 1, 0, 1, 0);
        apply("adh_only", 8'h00, 8'hA5, 0, 1, 1, 0);
        apply("load_4000", 8'h00, 8'h40, 1, 1, 0, 0);
        apply("hold1", 8'hFF, 8'hEE, 1, 1, 1, 1);
        apply("hold2", 8'h12, 8'h34, 1, 1, 1, 1);
        check("hold_const", 16'h4000, 1'b0);
        apply("after_hold", 8'h00, 8'h00, 0, 0, 1, 0);
        check("after_hold_const", 16'h4001, 1'b0);
        apply("pre_rst_carry", 8'hFF, 8'h10, 1, 1, 1, 0);
        hold = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        m_pc = 16'h0000; m_c = 1'b0;
        check("reset_over_hold", 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_edge", 16'h0000, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            apply("random", 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
